// File: rtl/bcd_3digit_down_cnt.sv
// Three-digit BCD down counter with load sanitizing, zero/done/err flags and an IDLE/RUN/EXPIRED FSM.
// Optional macro BCD_DOWN_CNT_AUTO_RELOAD_EN: EXPIRED with en reloads the last sanitized load value.
module bcd_3digit_down_cnt #(
    parameter logic [11:0] INIT_VAL = 12'h999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        en,
    output logic [11:0] cnt,
    output logic        zero,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [11:0] san_val;
    logic        san_bad;
    logic [11:0] dec_val;
`ifdef BCD_DOWN_CNT_AUTO_RELOAD_EN
    logic [11:0] reload_q, reload_d;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // One BCD step down; only called with a non-zero value, so hundreds never underflows.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h, t, o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (o == 4'd0) begin
            o = 4'd9;
            if (t == 4'd0) begin
                t = 4'd9;
                h = h - 4'd1;
            end else begin
                t = t - 4'd1;
            end
        end else begin
            o = o - 4'd1;
        end
        return {h, t, o};
    endfunction

    always_comb begin
        san_val = {clamp_digit(load_val[11:8]), clamp_digit(load_val[7:4]), clamp_digit(load_val[3:0])};
        san_bad = (load_val[11:8] > 4'd9) || (load_val[7:4] > 4'd9) || (load_val[3:0] > 4'd9);
        dec_val = bcd_dec(cnt_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef BCD_DOWN_CNT_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            cnt_d   = san_val;
            err_d   = san_bad;
            state_d = (san_val == 12'h000) ? EXPIRED : RUN;
`ifdef BCD_DOWN_CNT_AUTO_RELOAD_EN
            reload_d = san_val;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (cnt_q == 12'h000) begin
                        state_d = EXPIRED;
                    end else if (en) begin
                        cnt_d = dec_val;
                        if (dec_val == 12'h000) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
`ifdef BCD_DOWN_CNT_AUTO_RELOAD_EN
                    if (en && (reload_q != 12'h000)) begin
                        cnt_d   = reload_q;
                        state_d = RUN;
                    end
`else
                    state_d = EXPIRED;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        zero_d = (cnt_d == 12'h000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= INIT_VAL;
            zero_q  <= (INIT_VAL == 12'h000);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BCD_DOWN_CNT_AUTO_RELOAD_EN
            reload_q <= INIT_VAL;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BCD_DOWN_CNT_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign cnt  = cnt_q;
    assign zero = zero_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_3digit_down_cnt.sv
// Self-checking bench for bcd_3digit_down_cnt: directed scenarios plus randomized traffic
// compared against a decimal-integer model of the counter.
module tb_bcd_3digit_down_cnt;

    localparam logic [11:0] INIT_VAL = 12'h999;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [11:0] load_val = 12'h000;
    logic        en = 1'b0;
    logic [11:0] cnt;
    logic        zero;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Model state: value as a plain decimal integer, mode 0=idle 1=run 2=expired
    int m_val;
    int m_mode;
    int m_reload;
    bit m_done;
    bit m_err;

    bcd_3digit_down_cnt #(.INIT_VAL(INIT_VAL)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .cnt      (cnt),
        .zero     (zero),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic int bcd_to_int(input logic [11:0] v);
        return 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic int digit_min9(input logic [3:0] n);
        return (int'(n) > 9) ? 9 : int'(n);
    endfunction

    function automatic bit auto_reload_on();
`ifdef BCD_DOWN_CNT_AUTO_RELOAD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Applies one cycle of inputs, then advances the model using the counter's rules.
    task automatic cycle(input bit r, input bit l, input logic [11:0] lv, input bit e);
        int sv;
        rst = r;
        load = l;
        load_val = lv;
        en = e;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_val = bcd_to_int(INIT_VAL);
            m_mode = 0;
            m_reload = bcd_to_int(INIT_VAL);
        end else if (l) begin
            sv = 100 * digit_min9(lv[11:8]) + 10 * digit_min9(lv[7:4]) + digit_min9(lv[3:0]);
            m_err = (lv[11:8] > 4'd9) || (lv[7:4] > 4'd9) || (lv[3:0] > 4'd9);
            m_val = sv;
            m_reload = sv;
            m_mode = (sv == 0) ? 2 : 1;
        end else if (m_mode == 1 && e) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
                m_mode = 2;
                m_done = 1'b1;
            end
        end else if (m_mode == 2 && e && auto_reload_on() && m_reload != 0) begin
            m_val = m_reload;
            m_mode = 1;
        end
    endtask

    task automatic test_reset();
        cycle(1, 1, 12'h123, 1);
        vectors++;
        if (cnt !== INIT_VAL) begin
            miscompares++;
            $display("[TB] FAIL reset_cnt got %h want %h", cnt, INIT_VAL);
        end
        vectors++;
        if ({zero, done, err} !== {(INIT_VAL == 12'h000), 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got z%b d%b e%b want z%b d0 e0", zero, done, err, INIT_VAL == 12'h000);
        end
    endtask

    task automatic test_idle_ignore_en();
        cycle(1, 0, 12'h000, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 12'h000, 1);
            vectors++;
            if (cnt !== INIT_VAL || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_en cyc%0d got cnt %h done %b want %h 0", i, cnt, done, INIT_VAL);
            end
        end
    endtask

    task automatic test_count_down();
        cycle(1, 0, 12'h000, 0);
        cycle(0, 1, 12'h010, 1);
        vectors++;
        if (cnt !== 12'h010 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL cd_load got cnt %h done %b want 010 0", cnt, done);
        end
        for (int i = 1; i <= 10; i++) begin
            cycle(0, 0, 12'h000, 1);
            vectors++;
            if (cnt !== to_bcd(10 - i) || done !== (i == 10) || zero !== (i == 10)) begin
                miscompares++;
                $display("[TB] FAIL cd_step%0d got cnt %h done %b zero %b want %h %b %b",
                         i, cnt, done, zero, to_bcd(10 - i), i == 10, i == 10);
            end
        end
        cycle(0, 0, 12'h000, 1);
        vectors++;
        if (auto_reload_on()) begin
            if (cnt !== 12'h010 || done !== 1'b0 || zero !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL cd_after got cnt %h done %b zero %b want 010 0 0", cnt, done, zero);
            end
        end else begin
            if (cnt !== 12'h000 || done !== 1'b0 || zero !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL cd_after got cnt %h done %b zero %b want 000 0 1", cnt, done, zero);
            end
        end
    endtask

    task automatic test_double_borrow();
        cycle(0, 1, 12'h100, 0);
        cycle(0, 0, 12'h000, 1);
        vectors++;
        if (cnt !== 12'h099) begin
            miscompares++;
            $display("[TB] FAIL double_borrow got %h want 099", cnt);
        end
        cycle(0, 0, 12'h000, 1);
        vectors++;
        if (cnt !== 12'h098) begin
            miscompares++;
            $display("[TB] FAIL after_borrow got %h want 098", cnt);
        end
    endtask

    task automatic test_sanitize();
        cycle(0, 1, 12'h9AF, 0);
        vectors++;
        if (cnt !== 12'h999 || err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sanitize_9AF got cnt %h err %b want 999 1", cnt, err);
        end
        cycle(0, 0, 12'h000, 0);
        vectors++;
        if (cnt !== 12'h999 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_pulse got cnt %h err %b want 999 0", cnt, err);
        end
        cycle(0, 0, 12'h000, 1);
        vectors++;
        if (cnt !== 12'h998) begin
            miscompares++;
            $display("[TB] FAIL sanitize_run got %h want 998", cnt);
        end
        cycle(0, 1, 12'h0F3, 1);
        vectors++;
        if (cnt !== 12'h093 || err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sanitize_0F3 got cnt %h err %b want 093 1", cnt, err);
        end
    endtask

    task automatic test_load_priority();
        cycle(0, 1, 12'h050, 0);
        cycle(0, 1, 12'h123, 1);
        vectors++;
        if (cnt !== 12'h123 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_over_en got cnt %h err %b want 123 0", cnt, err);
        end
        cycle(0, 0, 12'h000, 1);
        vectors++;
        if (cnt !== 12'h122) begin
            miscompares++;
            $display("[TB] FAIL post_load_dec got %h want 122", cnt);
        end
        cycle(1, 1, 12'h456, 1);
        vectors++;
        if (cnt !== INIT_VAL) begin
            miscompares++;
            $display("[TB] FAIL rst_over_load got %h want %h", cnt, INIT_VAL);
        end
        cycle(0, 0, 12'h000, 1);
        vectors++;
        if (cnt !== INIT_VAL) begin
            miscompares++;
            $display("[TB] FAIL rst_to_idle got %h want %h", cnt, INIT_VAL);
        end
    endtask

    task automatic test_expired();
        logic [11:0] want [5];
        bit          want_done [5];
        want[0] = 12'h002; want[1] = 12'h001; want[2] = 12'h000;
        want[3] = auto_reload_on() ? 12'h002 : 12'h000;
        want[4] = auto_reload_on() ? 12'h001 : 12'h000;
        want_done = '{0, 0, 1, 0, 0};
        cycle(1, 0, 12'h000, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, i == 0, 12'h002, 1);
            vectors++;
            if (cnt !== want[i] || done !== want_done[i]) begin
                miscompares++;
                $display("[TB] FAIL expired_seq%0d got cnt %h done %b want %h %b", i, cnt, done, want[i], want_done[i]);
            end
        end
        cycle(0, 1, 12'h000, 1);
        vectors++;
        if (cnt !== 12'h000 || zero !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_zero got cnt %h zero %b done %b want 000 1 0", cnt, zero, done);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 12'h000, 1);
            vectors++;
            if (cnt !== 12'h000 || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL zero_hold%0d got cnt %h done %b want 000 0", i, cnt, done);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] lv;
        bit r, l, e;
        cycle(1, 0, 12'h000, 0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                lv = {4'h0, 4'h0, 4'($urandom_range(0, 12))};
            else
                lv = 12'($urandom);
            cycle(r, l, lv, e);
            vectors++;
            if (cnt !== to_bcd(m_val) || zero !== (m_val == 0) || done !== m_done || err !== m_err) begin
                miscompares++;
                $display("[TB] FAIL random%0d got cnt %h z%b d%b e%b want %h z%b d%b e%b",
                         i, cnt, zero, done, err, to_bcd(m_val), m_val == 0, m_done, m_err);
            end
            vectors++;
            if (cnt[11:8] > 4'd9 || cnt[7:4] > 4'd9 || cnt[3:0] > 4'd9) begin
                miscompares++;
                $display("[TB] FAIL random_digit%0d got cnt %h want all digits 0-9", i, cnt);
            end
        end
    endtask

    initial begin
        m_val = 0;
        m_mode = 0;
        m_reload = 0;
        m_done = 1'b0;
        m_err = 1'b0;
        test_reset();
        test_idle_ignore_en();
        test_count_down();
        test_double_borrow();
        test_sanitize();
        test_load_priority();
        test_expired();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
